// File: rtl/fpga_cfg_loader.sv
// Byte-serial bitstream loader: SYNC_BYTE, ceil(CFG_WIDTH/8) payload bytes, optional checksum byte.
// Define CFG_LOADER_CHECKSUM_EN to add the CHECK state and reject frames whose byte sum is non-zero.
module fpga_cfg_loader #(
    parameter int         CFG_WIDTH = 2828,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           bs_data,
    input  logic                 bs_valid,
    output logic                 bs_ready,
    output logic [CFG_WIDTH-1:0] cfg_bits,
    output logic                 cfg_done,
    output logic                 cfg_error,
    output logic                 cfg_busy
);

    localparam int               NBYTES = (CFG_WIDTH + 7) / 8;
    localparam int               CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(NBYTES - 1);

`ifdef CFG_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CHECK = 2'd2, S_COMMIT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_COMMIT = 2'd3} state_t;
`endif

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CFG_WIDTH-1:0] shadow;
    logic                 xfer, sync_hit, commit_ok;

    // Ready depends only on the registered state; COMMIT is the single bubble.
    assign bs_ready = (state != S_COMMIT);
    assign cfg_busy = (state != S_IDLE);
    assign xfer     = bs_valid && bs_ready;
    assign sync_hit = (state == S_IDLE) && xfer && (bs_data == SYNC_BYTE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (sync_hit) state_nxt = S_LOAD;
`ifdef CFG_LOADER_CHECKSUM_EN
            S_LOAD:   if (xfer && cnt == LAST) state_nxt = S_CHECK;
            S_CHECK:  if (xfer) state_nxt = S_COMMIT;
`else
            S_LOAD:   if (xfer && cnt == LAST) state_nxt = S_COMMIT;
`endif
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)                           cnt <= '0;
        else if (sync_hit)                 cnt <= '0;
        else if (state == S_LOAD && xfer)  cnt <= cnt + 1'b1;
    end

    // Pad bits of the final byte fall outside the vector and are simply not stored.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && xfer) begin
            for (int b = 0; b < 8; b++) begin
                if (int'(cnt) * 8 + b < CFG_WIDTH)
                    shadow[int'(cnt) * 8 + b] <= bs_data[b];
            end
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [7:0] sum, sum_nxt;
    logic       pass;

    assign sum_nxt = sum + bs_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            pass <= 1'b0;
        end else if (sync_hit) begin
            sum  <= '0;
        end else if (state == S_LOAD && xfer) begin
            sum  <= sum_nxt;
        end else if (state == S_CHECK && xfer) begin
            pass <= (sum_nxt == 8'h00);
        end
    end

    assign commit_ok = pass;

    always_ff @(posedge clk) begin
        if (rst)                                 cfg_error <= 1'b0;
        else if (sync_hit)                       cfg_error <= 1'b0;
        else if (state == S_COMMIT && !commit_ok) cfg_error <= 1'b1;
    end
`else
    assign commit_ok = 1'b1;
    assign cfg_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_bits <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (state == S_COMMIT && commit_ok) begin
                cfg_bits <= shadow;
                cfg_done <= 1'b1;
            end
        end
    end

endmodule
